// File: rtl/cla64_seq_driver_if.sv
// Operand/result bus for cla64_seq_driver.
// Request side: in_valid/in_ready carry op_a, op_b, op_sub and op_cin.
// Result side: res_valid/res_ready carry res, cout and ovf.
// Build option CLA64_SEQ_FLAGS_EN adds the res_zero and res_neg flag signals.
// The master modport is the producer/consumer; the slave modport is the sequencer.
interface cla64_seq_driver_if #(
    parameter int DATA_W = 64
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              op_sub;
    logic              op_cin;
    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res;
    logic              cout;
    logic              ovf;
`ifdef CLA64_SEQ_FLAGS_EN
    logic              res_zero;
    logic              res_neg;

    modport master (
        output in_valid, op_a, op_b, op_sub, op_cin, res_ready,
        input  in_ready, res_valid, res, cout, ovf, res_zero, res_neg
    );

    modport slave (
        input  in_valid, op_a, op_b, op_sub, op_cin, res_ready,
        output in_ready, res_valid, res, cout, ovf, res_zero, res_neg
    );
`else
    modport master (
        output in_valid, op_a, op_b, op_sub, op_cin, res_ready,
        input  in_ready, res_valid, res, cout, ovf
    );

    modport slave (
        input  in_valid, op_a, op_b, op_sub, op_cin, res_ready,
        output in_ready, res_valid, res, cout, ovf
    );
`endif
endinterface

// File: rtl/cla64_seq_driver.sv
// cla64_seq_driver: multi-cycle 64-bit add/subtract built on one shared CLA group.
// The operation is split into NUM_BEATS slices of GRP_W bits. One slice goes to the
// external group each beat, and the carry ripples between slices as GF | (PF & cin).
// The group is trusted to be combinational: grp_sum/grp_pf/grp_gf are used in the
// same cycle that grp_x/grp_y/grp_cin are driven.
// Build option CLA64_SEQ_FLAGS_EN adds the res_zero/res_neg result flags.
module cla64_seq_driver #(
    parameter int GRP_W     = 16,
    parameter int NUM_BEATS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    cla64_seq_driver_if.slave  bus,
    output logic [GRP_W-1:0]   grp_x,
    output logic [GRP_W-1:0]   grp_y,
    output logic [GRP_W-1:0]   grp_cin,
    input  logic [GRP_W-1:0]   grp_sum,
    input  logic               grp_pf,
    input  logic               grp_gf
);

    localparam int DATA_W = GRP_W * NUM_BEATS;
    // Keep at least one bit so the design still elaborates when NUM_BEATS = 1.
    localparam int BEAT_W = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_reg, state_next;
    logic [BEAT_W-1:0]   beat_reg, beat_next;
    logic                carry_reg, carry_next;
    logic [DATA_W-1:0]   a_reg, a_next;
    // b_reg holds B' (B already inverted for subtract), so the group only ever adds.
    logic [DATA_W-1:0]   b_reg, b_next;
    logic [DATA_W-1:0]   res_reg, res_next;
    logic                cout_reg, cout_next;
    logic                ovf_reg, ovf_next;

    logic [GRP_W-1:0]    a_slice [NUM_BEATS];
    logic [GRP_W-1:0]    b_slice [NUM_BEATS];
    logic                run_active;
    logic                last_beat;
    logic                slice_cout;

    assign run_active = (state_reg == RUN);
    assign last_beat  = (beat_reg == BEAT_W'(NUM_BEATS - 1));
    // Ripple carry out of the current slice, fed to the next beat.
    assign slice_cout = grp_gf | (grp_pf & carry_reg);

`ifdef CLA64_SEQ_FLAGS_EN
    logic zero_acc_reg, zero_acc_next;
    logic res_zero_reg, res_zero_next;
    logic res_neg_reg,  res_neg_next;
    logic slice_zero;

    assign slice_zero = (grp_sum == '0);
`endif

    // Slice views of the latched operands and per-slice result write-back.
    for (genvar gi = 0; gi < NUM_BEATS; gi++) begin : g_slice
        assign a_slice[gi] = a_reg[gi*GRP_W +: GRP_W];
        assign b_slice[gi] = b_reg[gi*GRP_W +: GRP_W];
        // Only the slice of the current beat is overwritten; the rest of res is held.
        assign res_next[gi*GRP_W +: GRP_W] =
            (run_active && (beat_reg == BEAT_W'(gi))) ? grp_sum
                                                      : res_reg[gi*GRP_W +: GRP_W];
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state, datapath next values and group drive.
    always_comb begin
        state_next = state_reg;
        beat_next  = beat_reg;
        carry_next = carry_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        cout_next  = cout_reg;
        ovf_next   = ovf_reg;
        grp_x      = '0;
        grp_y      = '0;
        grp_cin    = '0;
`ifdef CLA64_SEQ_FLAGS_EN
        zero_acc_next = zero_acc_reg;
        res_zero_next = res_zero_reg;
        res_neg_next  = res_neg_reg;
`endif
        unique case (state_reg)
            IDLE: begin
                if (bus.in_valid) begin
                    a_next     = bus.op_a;
                    b_next     = bus.op_sub ? ~bus.op_b : bus.op_b;
                    // Subtract is A + ~B + 1, so op_cin is ignored there.
                    carry_next = bus.op_sub ? 1'b1 : bus.op_cin;
                    beat_next  = '0;
`ifdef CLA64_SEQ_FLAGS_EN
                    zero_acc_next = 1'b1;
`endif
                    state_next = RUN;
                end
            end
            RUN: begin
                grp_x      = a_slice[beat_reg];
                grp_y      = b_slice[beat_reg];
                grp_cin    = {{(GRP_W-1){1'b0}}, carry_reg};
                carry_next = slice_cout;
`ifdef CLA64_SEQ_FLAGS_EN
                zero_acc_next = zero_acc_reg & slice_zero;
`endif
                if (last_beat) begin
                    // Counter stays on the last beat rather than wrapping.
                    state_next = DONE;
                    cout_next  = slice_cout;
                    // Overflow when the operand signs agree but the result sign differs.
                    ovf_next   = (a_reg[DATA_W-1] == b_reg[DATA_W-1]) &
                                 (grp_sum[GRP_W-1] != a_reg[DATA_W-1]);
`ifdef CLA64_SEQ_FLAGS_EN
                    res_zero_next = zero_acc_reg & slice_zero;
                    res_neg_next  = grp_sum[GRP_W-1];
`endif
                end else begin
                    beat_next = beat_reg + 1'b1;
                end
            end
            DONE: begin
                if (bus.res_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_reg  <= '0;
            carry_reg <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            res_reg   <= '0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            beat_reg  <= beat_next;
            carry_reg <= carry_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            res_reg   <= res_next;
            cout_reg  <= cout_next;
            ovf_reg   <= ovf_next;
        end
    end

`ifdef CLA64_SEQ_FLAGS_EN
    // Result flag registers, updated together with cout/ovf on the final beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_acc_reg <= 1'b0;
            res_zero_reg <= 1'b0;
            res_neg_reg  <= 1'b0;
        end else begin
            zero_acc_reg <= zero_acc_next;
            res_zero_reg <= res_zero_next;
            res_neg_reg  <= res_neg_next;
        end
    end

    assign bus.res_zero = res_zero_reg;
    assign bus.res_neg  = res_neg_reg;
`endif

    // The handshake outputs are decoded straight from the state.
    assign bus.in_ready  = (state_reg == IDLE);
    assign bus.res_valid = (state_reg == DONE);
    assign bus.res       = res_reg;
    assign bus.cout      = cout_reg;
    assign bus.ovf       = ovf_reg;

endmodule

// File: tb/tb_cla64_seq_driver.sv
// Testbench for cla64_seq_driver with a behavioural 16-bit CLA group model.
// The scoreboard queue is filled as each operation is issued; a negedge monitor pops
// and compares on every accepted result. The res_zero/res_neg flags are also
// compared when CLA64_SEQ_FLAGS_EN is defined.
module tb_cla64_seq_driver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] grp_x, grp_y, grp_cin, grp_sum;
    logic        grp_pf, grp_gf;
    logic [16:0] grp_raw;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [63:0] res;
        logic        cout;
        logic        ovf;
        logic        zero;
        logic        neg;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    cla64_seq_driver_if #(.DATA_W(64)) bus ();

    cla64_seq_driver #(.GRP_W(16), .NUM_BEATS(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .grp_x   (grp_x),
        .grp_y   (grp_y),
        .grp_cin (grp_cin),
        .grp_sum (grp_sum),
        .grp_pf  (grp_pf),
        .grp_gf  (grp_gf)
    );

    always #5 clk = ~clk;

    // Group model: the sum includes the carry-in; GF is the carry out with cin = 0;
    // PF is high when every bit propagates.
    assign grp_raw = {1'b0, grp_x} + {1'b0, grp_y};
    assign grp_sum = grp_raw[15:0] + grp_cin;
    assign grp_gf  = grp_raw[16];
    assign grp_pf  = &(grp_x ^ grp_y);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: one comparison set per result handshake.
    always @(negedge clk) begin
        if (rst_n && bus.res_valid && bus.res_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got res %h expected no result", bus.res);
            end else begin
                mon_e = sb_q.pop_front();
                $display("result res=%h cout=%0b ovf=%0b (expected %h %0b %0b)",
                         bus.res, bus.cout, bus.ovf, mon_e.res, mon_e.cout, mon_e.ovf);
                check("res", bus.res, mon_e.res);
                check("cout", 64'(bus.cout), 64'(mon_e.cout));
                check("ovf", 64'(bus.ovf), 64'(mon_e.ovf));
`ifdef CLA64_SEQ_FLAGS_EN
                check("res_zero", 64'(bus.res_zero), 64'(mon_e.zero));
                check("res_neg", 64'(bus.res_neg), 64'(mon_e.neg));
`endif
            end
        end
    end

    // Wait for in_ready, present the operands for one edge, and check beat 0 drive.
    // Returns #1 after the accept edge.
    task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic sub,
                         input logic cin, input bit push, input exp_t e);
        int          n;
        logic [63:0] bp;
        logic        c0;
        n  = 0;
        bp = sub ? ~b : b;
        c0 = sub ? 1'b1 : cin;
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("issue_ready", 64'(bus.in_ready), 64'd1);
        bus.in_valid = 1'b1;
        bus.op_a     = a;
        bus.op_b     = b;
        bus.op_sub   = sub;
        bus.op_cin   = cin;
        if (push) sb_q.push_back(e);
        $display("issue a=%h b=%h sub=%0b cin=%0b", a, b, sub, cin);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("beat0_x", 64'(grp_x), 64'(a[15:0]));
        check("beat0_y", 64'(grp_y), 64'(bp[15:0]));
        check("beat0_cin", 64'(grp_cin), 64'({15'b0, c0}));
    endtask

    // One full operation: issue, latency check, optional backpressure, drain.
    task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic sub,
                          input logic cin, input logic [63:0] r, input logic co,
                          input logic ov, input logic z, input logic ng, input int hold);
        exp_t e;
        int   edges;
        e.res = r; e.cout = co; e.ovf = ov; e.zero = z; e.neg = ng;
        issue(a, b, sub, cin, 1'b1, e);
        // The accept edge counts as the first of the five.
        edges = 1;
        while (!bus.res_valid && edges < 20) begin
            @(posedge clk);
            #1;
            edges++;
        end
        check("latency", 64'(edges), 64'd5);
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = i[0];
            bus.op_a     = {32'(i), 32'(i)};
            bus.op_b     = 64'(i);
            @(posedge clk);
            #1;
            check("bp_res", bus.res, r);
            check("bp_in_ready", 64'(bus.in_ready), 64'd0);
            check("bp_valid", 64'(bus.res_valid), 64'd1);
        end
        bus.in_valid  = 1'b0;
        bus.res_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.res_ready = 1'b0;
        check("idle_in_ready", 64'(bus.in_ready), 64'd1);
        check("idle_valid", 64'(bus.res_valid), 64'd0);
    endtask

    initial begin
        exp_t dummy;
        dummy.res = '0; dummy.cout = 1'b0; dummy.ovf = 1'b0; dummy.zero = 1'b0; dummy.neg = 1'b0;
        bus.in_valid  = 1'b0;
        bus.op_a      = '0;
        bus.op_b      = '0;
        bus.op_sub    = 1'b0;
        bus.op_cin    = 1'b0;
        bus.res_ready = 1'b0;

        // Reset values.
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_valid", 64'(bus.res_valid), 64'd0);
        check("rst_res", bus.res, 64'd0);
        check("rst_cout", 64'(bus.cout), 64'd0);
        check("rst_ovf", 64'(bus.ovf), 64'd0);
        check("rst_grp_x", 64'(grp_x), 64'd0);
        check("rst_grp_cin", 64'(grp_cin), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        //     a                       b                       sub   cin   res                     cout  ovf   zero  neg   hold
        run_op(64'h0000_0000_0000_FFFF, 64'h1,                 1'b0, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1,                 1'b0, 1'b0, 64'h0,                   1'b1, 1'b0, 1'b1, 1'b0, 0);
        run_op(64'h5,                   64'h7,                 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        run_op(64'h10,                  64'h3,                 1'b1, 1'b0, 64'hD,                   1'b1, 1'b0, 1'b0, 1'b0, 0);
        run_op(64'h1234,                64'h1,                 1'b0, 1'b1, 64'h1236,                1'b0, 1'b0, 1'b0, 1'b0, 0);
        run_op(64'h8000_0000_0000_0000, 64'h1,                 1'b1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        // Signed overflow, held in DONE for 10 cycles with in_valid toggling.
        run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1,                 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0, 1'b1, 10);

        // Nothing was accepted while DONE was held.
        repeat (3) @(posedge clk);
        #1;
        check("no_accept_valid", 64'(bus.res_valid), 64'd0);
        check("no_accept_ready", 64'(bus.in_ready), 64'd1);

        // Reset at beat 2 aborts the operation; nothing is queued for it.
        issue(64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 1'b0, 1'b0, 1'b0, dummy);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", 64'(bus.in_ready), 64'd1);
        check("midrst_valid", 64'(bus.res_valid), 64'd0);
        check("midrst_res", bus.res, 64'd0);
        check("midrst_cout", 64'(bus.cout), 64'd0);
        check("midrst_ovf", 64'(bus.ovf), 64'd0);
        check("midrst_grp_x", 64'(grp_x), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(64'h1, 64'h2, 1'b0, 1'b0, 64'h3, 1'b0, 1'b0, 1'b0, 1'b0, 0);

        repeat (2) @(posedge clk);
        #1;
        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global bound so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog timeout");
    end

endmodule
